// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the inverse cipher core: FSM state type,
// round constants, GF(2^8) arithmetic helpers and the state-wide
// InvShiftRows / InvMixColumns transforms.
// State layout: byte i = 4*c + r sits at bits [127-8*i -: 8].
package aes_pkg;

  localparam int unsigned NR = 10;
  localparam int unsigned NK = 4;

  typedef enum logic [2:0] {IDLE, KEYEXP, ROUND, FINAL, DONE} state_t;

  // Entry 0 and 11..15 are never used; padding keeps any 4-bit index in range.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119 - 32 * c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111 - 32 * c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103 - 32 * c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_core_inv_sbox.sv
// Inverse AES S-box (combinational): inverse affine map followed by GF(2^8) inverse.
// Ports: a - input byte, s - substituted byte.
module inv_sbox import aes_pkg::*; (
  input  logic [7:0] a,
  output logic [7:0] s
);
  logic [7:0] t;

  always_comb begin
    t = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
    s = gf_inv(t);
  end
endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box (combinational): GF(2^8) inverse followed by the affine map.
// Ports: a - input byte, s - substituted byte.
module aes_sbox import aes_pkg::*; (
  input  logic [7:0] a,
  output logic [7:0] s
);
  logic [7:0] b;

  always_comb begin
    b = gf_inv(a);
    s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  end
endmodule

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES-128 inverse cipher. Expands the key forward to round key 10,
// then runs the rounds while stepping the key schedule backwards.
// Ports: clk, reset (async, active-high), start (accepted in IDLE/DONE),
// key / cyphertext (captured on start), plaintext (registered result),
// busy (run in progress), done (result valid until next start or reset).
module aes_inv_cipher_core import aes_pkg::*; (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] cyphertext,
  output logic [127:0] plaintext,
  output logic         busy,
  output logic         done
);
  localparam logic [3:0] LAST_RC = 4'(NR);

  state_t       state, state_next;
  logic [127:0] rk, st;
  logic [3:0]   cnt;
  logic         do_load, do_keyexp, do_round, do_final;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sb_in, sb_out;
  logic [7:0]   rc;
  logic [31:0]  t, f0, f1, f2, f3, p0, p1, p2, p3;
  logic [127:0] rk_fwd, rk_inv, isr, isb, imc;

  assign {w0, w1, w2, w3} = rk;

  // One word of S-boxes serves both directions of the key schedule:
  // forward uses w3, backward uses the recovered w3 of the previous key.
  assign sb_in = (state == KEYEXP) ? rot_word(w3) : rot_word(w3 ^ w2);
  assign rc    = (state == KEYEXP) ? RCON[cnt] : RCON[cnt + 4'd1];

  for (genvar g = 0; g < 4; g++) begin : g_key_sbox
    aes_sbox u_sbox (.a(sb_in[31 - 8 * g -: 8]), .s(sb_out[31 - 8 * g -: 8]));
  end

  always_comb begin
    t  = sb_out ^ {rc, 24'h0};
    f0 = w0 ^ t;
    f1 = w1 ^ f0;
    f2 = w2 ^ f1;
    f3 = w3 ^ f2;
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    p0 = w0 ^ sb_out ^ {rc, 24'h0};
    rk_fwd = {f0, f1, f2, f3};
    rk_inv = {p0, p1, p2, p3};
  end

  assign isr = inv_shift_rows(st);

  for (genvar g = 0; g < 16; g++) begin : g_state_sbox
    inv_sbox u_inv_sbox (.a(isr[127 - 8 * g -: 8]), .s(isb[127 - 8 * g -: 8]));
  end

  assign imc = inv_mix_columns(isb ^ rk_inv);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = KEYEXP;
      KEYEXP:     if (cnt == LAST_RC) state_next = ROUND;
      ROUND:      if (cnt == 4'd1) state_next = FINAL;
      FINAL:      state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    do_load   = 1'b0;
    do_keyexp = 1'b0;
    do_round  = 1'b0;
    do_final  = 1'b0;
    case (state)
      IDLE, DONE: do_load   = start;
      KEYEXP:     do_keyexp = 1'b1;
      ROUND:      do_round  = 1'b1;
      FINAL:      do_final  = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rk        <= '0;
      st        <= '0;
      cnt       <= '0;
      plaintext <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (do_load) begin
        rk   <= key;
        st   <= cyphertext;
        cnt  <= 4'd1;
        busy <= 1'b1;
        done <= 1'b0;
      end
      if (do_keyexp) begin
        rk <= rk_fwd;
        if (cnt == LAST_RC) begin
          // Initial AddRoundKey uses round key 10 as it is produced.
          st  <= st ^ rk_fwd;
          cnt <= LAST_RC - 4'd1;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
      if (do_round) begin
        st  <= imc;
        rk  <= rk_inv;
        cnt <= cnt - 4'd1;
      end
      if (do_final) begin
        plaintext <= isb ^ rk_inv;
        done      <= 1'b1;
        busy      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_aes_inv_cipher_core.sv
module tb_aes_inv_cipher_core;
  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] key;
  logic [127:0] cyphertext;
  logic [127:0] plaintext;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  aes_inv_cipher_core dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key       (key),
    .cyphertext(cyphertext),
    .plaintext (plaintext),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t vecs [3];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents inputs and pulses start across one rising edge (E0); returns #1 after E0.
  task automatic begin_run(input logic [127:0] k, input logic [127:0] c, input logic hold);
    @(negedge clk);
    key        = k;
    cyphertext = c;
    start      = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Counts rising edges until done, with a bounded budget; reports busy drops on the way.
  task automatic wait_done(input int n0, output int n, output int busy_low);
    n        = n0;
    busy_low = 0;
    while (!done && n < n0 + 60) begin
      @(posedge clk);
      #1;
      n++;
      if (!done && !busy) busy_low++;
    end
  endtask

  int           n;
  int           bl;
  logic [127:0] prev_pt;

  initial begin
    vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                pt:  128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct:  128'h3925841d02dc09fbdc118597196a0b32,
                pt:  128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{key: 128'h0,
                ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                pt:  128'h0};

    reset = 1'b1; start = 1'b0; key = '0; cyphertext = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_plaintext", plaintext, 128'h0);
    chk("reset_busy", 128'(busy), 128'h0);
    chk("reset_done", 128'(done), 128'h0);
    @(negedge clk);
    reset = 1'b0;

    prev_pt = '0;
    for (int i = 0; i < 3; i++) begin
      begin_run(vecs[i].key, vecs[i].ct, 1'b0);
      chk($sformatf("v%0d_busy_e0", i), 128'(busy), 128'h1);
      chk($sformatf("v%0d_done_e0", i), 128'(done), 128'h0);
      repeat (4) @(posedge clk);
      #1;
      chk($sformatf("v%0d_pt_hold", i), plaintext, prev_pt);
      wait_done(4, n, bl);
      chk($sformatf("v%0d_latency", i), 128'(n), 128'd20);
      chk($sformatf("v%0d_busy_gap", i), 128'(bl), 128'h0);
      chk($sformatf("v%0d_plaintext", i), plaintext, vecs[i].pt);
      chk($sformatf("v%0d_busy_end", i), 128'(busy), 128'h0);
      prev_pt = vecs[i].pt;
    end

    // Round key 10 visible after the tenth key-expansion edge.
    begin_run(vecs[1].key, vecs[1].ct, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("b_rk10", dut.rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    wait_done(10, n, bl);
    chk("b_latency", 128'(n), 128'd20);
    chk("b_plaintext", plaintext, vecs[1].pt);

    // Start pulse mid-run with other inputs is ignored.
    begin_run(vecs[0].key, vecs[0].ct, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    key = vecs[1].key; cyphertext = vecs[1].ct; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(5, n, bl);
    chk("ign_latency", 128'(n), 128'd20);
    chk("ign_plaintext", plaintext, vecs[0].pt);

    // Reset in the middle of a run.
    begin_run(vecs[1].key, vecs[1].ct, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_done", 128'(done), 128'h0);
    chk("rst_plaintext", plaintext, 128'h0);
    @(negedge clk);
    reset = 1'b0;
    begin_run(vecs[0].key, vecs[0].ct, 1'b0);
    wait_done(0, n, bl);
    chk("rst_rerun_latency", 128'(n), 128'd20);
    chk("rst_rerun_plaintext", plaintext, vecs[0].pt);

    // Start held high: restart on the first edge in DONE.
    begin_run(vecs[0].key, vecs[0].ct, 1'b1);
    wait_done(0, n, bl);
    chk("b2b_latency1", 128'(n), 128'd20);
    chk("b2b_plaintext1", plaintext, vecs[0].pt);
    @(posedge clk);
    #1;
    n++;
    chk("b2b_done_drop", 128'(done), 128'h0);
    chk("b2b_busy_restart", 128'(busy), 128'h1);
    wait_done(n, n, bl);
    start = 1'b0;
    chk("b2b_latency2", 128'(n), 128'd41);
    chk("b2b_plaintext2", plaintext, vecs[0].pt);

    // Idle hold: inputs change without start.
    @(negedge clk);
    key = vecs[2].key; cyphertext = vecs[2].ct;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_plaintext", plaintext, vecs[0].pt);
    chk("idle_done", 128'(done), 128'h1);
    chk("idle_busy", 128'(busy), 128'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/aes_inv_cipher_core.md
Name: aes_inv_cipher_core

Overview:
Iterative AES-128 inverse cipher. Decrypts one 128-bit block per start request, using a round loop built from InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns. It derives the final round key with an on-the-fly forward key expansion, then walks the schedule backwards. It is the decrypt-side counterpart to the encrypt datapath and sits beside the encrypt core under the same top-level SPI/host wrapper.

Parameters:
None. AES-128 is fixed: Nk=4, Nr=10.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
key  input  128  cipher key; byte 0 = key[127:120]
cyphertext  input  128  input block; column-major, s(r,c) = bits [127-8*(4c+r) -: 8]
plaintext  output  128  registered result; valid while done=1
busy  output  1  high from the cycle after start is accepted until done rises
done  output  1  level; high from completion until the next accepted start or reset

Behaviour:
- Reset (async, any state): FSM=IDLE; plaintext=0; busy=0; done=0; round counter=0; internal key/state registers=0.
- FSM states: IDLE, KEYEXP, ROUND, FINAL, DONE.
- IDLE/DONE + start=1 at edge E0:
  - Capture key into rk and cyphertext into st.
  - counter<=1; busy<=1; done<=0; go to KEYEXP.
  - plaintext holds its old value until the new result is written.
- KEYEXP, edges E1..E10: rk <= fwd_expand(rk, Rcon[counter]); counter++.
  - At E10: rk=round key 10 and st <= st ^ rk10; go to ROUND with counter=9.
- ROUND, edges E11..E19, counter 9 down to 1:
  - rk_prev = inv_expand(rk, Rcon[counter+1]).
  - st <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(st)), rk_prev)); rk <= rk_prev; counter--.
- FINAL, edge E20: rk0 = inv_expand(rk, Rcon[1]).
  - plaintext <= InvSubBytes(InvShiftRows(st)) ^ rk0.
  - done<=1; busy<=0; go to DONE.
- Latency: done is high after exactly 20 rising edges following the start-sampling edge. No pipelining; one block in flight.
- InvShiftRows: row r rotates right by r columns, i.e. s'(r,c) = s(r,(c-r) mod 4). Row 0 is unchanged.
- fwd_expand(w0..w3, rc):
  - t = SubWord(RotWord(w3)) ^ {rc,00,00,00}
  - w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'
- inv_expand(w0..w3, rc):
  - w3p=w3^w2; w2p=w2^w1; w1p=w1^w0
  - w0p = w0 ^ SubWord(RotWord(w3p)) ^ {rc,00,00,00}
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- InvMixColumns: GF(2^8) with poly 0x11b; coefficient matrix {0e,0b,0d,09} circulant.
- start while busy (KEYEXP/ROUND/FINAL): ignored. Inputs changing while busy have no effect.
- start held high continuously: a new decryption starts at the first edge in DONE; done drops for that run.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No partial result is exposed.

Decomposition:
- Package aes_pkg:
  - state_t enum (IDLE, KEYEXP, ROUND, FINAL, DONE)
  - RCON constant array
  - functions xtime, gmul, rot_word
  - constants NR=10, NK=4
- Sub-module inv_sbox (combinational, 8-bit in/out), instantiated 16x for the state.
- Forward sbox (existing module) instantiated 4x, shared by fwd_expand and inv_expand via a state-selected mux.
- InvShiftRows and InvMixColumns as functions in the package. No further modules.

Test Plan:
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, cyphertext=69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext=00112233445566778899aabbccddeeff. done rises exactly 20 edges after start; busy high for cycles 1..19.
- FIPS-197 B: key=2b7e151628aed2a6abf7158809cf4f3c, cyphertext=3925841d02dc09fbdc118597196a0b32 -> plaintext=3243f6a8885a308d313198a2e0370734. Internal rk after E10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Pulse start at cycle 5 of a run with different key/cyphertext -> ignored; result still matches the original vector.
- Assert reset at E12 of a run -> busy=0, done=0, plaintext=0 immediately. A fresh start of C.1 then completes correctly in 20 edges.
- Back-to-back: start held high -> C.1 result, done high 1 cycle, next run restarts (done low, busy high) and yields the same plaintext.
- Idle hold: after done, toggle key/cyphertext without start -> plaintext and done unchanged.
